ysyx_040066_mul_wallace_pipe: RTL
=================================

Name: ysyx_040066_mul_wallace_pipe

Overview:
- Parametrised, pipelined integer multiplier for the RV64M datapath.
- Performs radix-4 Booth partial-product generation, then a generic 3:2 carry-save compression tree that reduces every column to two rows, then a final carry-propagate add.
- Successor to the fixed 33-input single-column compressor slice: column height and tree depth derive from XLEN.
- Adds valid/ready handshake, a flush input, RISC-V M-extension op modes and a tag passthrough.

Parameters:
XLEN, 64, operand/result width; must be even, valid values 32 or 64
TAG_W, 5, width of sideband tag carried alongside each operation (e.g. rd index)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; others reserved
src1  input  XLEN  multiplicand (rs1)
src2  input  XLEN  multiplier (rs2)
tag_in  input  TAG_W  sideband tag
flush  input  1  kill all in-flight operations
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  selected product bits
tag_out  output  TAG_W  tag of the operation on result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0, result=0, tag_out=0; in_ready=1 once reset deasserts.
- Three registered stages, fixed latency of 3 cycles from accept to out_valid when not stalled.
  - S1: Booth encode plus XLEN/2+1 partial products.
  - S2: CSA tree down to sum/carry rows (2*XLEN+2 bits).
  - S3: final add plus result select; drives result/tag_out.
- Accept: handshake fires when in_valid && in_ready.
- Advance: stage k advances when it is empty or stage k+1 advances. S3 drains when out_ready.
- in_ready = !S1_valid || S1 advances, so back-to-back issue gives throughput 1/cycle.
- Stall: out_valid && !out_ready holds result/tag_out stable. Upstream stages fill and then in_ready drops; no bubble is squeezed out and no data is lost.
- Operand extension to XLEN+2 bits before Booth:
  - MUL/MULH: both operands signed.
  - MULHSU: src1 signed, src2 zero-extended.
  - MULHU: both zero-extended.
  - MULW: src1[31:0], src2[31:0], sign-extended.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - MULW: sign-extend product[31:0] to XLEN.
- Reserved op codes behave as MUL.
- Arithmetic is exact modulo 2^(2*XLEN). Booth negation uses a +1 correction bit injected into the tree, not a separate adder.
- Flush: on a cycle with flush=1, all valid bits clear at the next edge and out_valid=0 the following cycle.
  - in_valid is ignored that cycle; in_ready may read 1 but no accept occurs.
  - Flush takes priority over a simultaneous out_ready handshake: that result is still considered delivered if out_valid && out_ready were both high.
- Reset mid-operation discards everything with no residual output.
- Data registers need not be cleared on flush; only the valid bits matter. result/tag_out are don't-care while out_valid=0, except for the reset value.

Test Plan:
- XLEN=64, MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE exactly 3 cycles after accept, tag_out equals tag_in.
- MULH src1=src2=-1 -> result 0; MUL src1=0x8000000000000000, src2=-1 -> result 0x8000000000000000.
- MULHSU src1=-1, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF. MULW src1=0x7FFFFFFF, src2=2 (upper bits garbage 0xDEAD...) -> 0xFFFFFFFFFFFFFFFE.
- Issue 6 back-to-back ops with out_ready=0 -> exactly 3 accepted, in_ready=0 after; release out_ready -> results emerge in order, one per cycle, values unchanged during stall.
- Flush asserted with 3 ops in flight plus in_valid=1 -> no out_valid for any of them; next op accepted after flush completes in 3 cycles.
- Assert rst_n low mid-stream -> out_valid, result, tag_out 0 immediately (asynchronously). Then run 10k random ops/modes at XLEN=32 and 64 against a reference model, with random out_ready and flush.

Source files
------------

// File: rtl/ysyx_040066_mul_wallace_pipe.sv
// Three-stage pipelined RV64M multiplier: radix-4 Booth partial products,
// a generic 3:2 carry-save tree down to two rows, then a carry-propagate
// add with M-extension result selection. valid/ready handshake with flush.
module ysyx_040066_mul_wallace_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  // Number of 3:2 levels needed to bring a column of 'rows' entries to two.
  function automatic int csa_levels(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  localparam int OW   = XLEN + 2;       // extended operand width
  localparam int NPP  = XLEN / 2 + 1;   // Booth partial products
  localparam int PW   = 2 * XLEN + 2;   // product width kept in the tree
  localparam int NR   = NPP + 1;        // partial products plus correction row
  localparam int LVLS = csa_levels(NR);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  // One Booth row from a multiplier triplet {y[2i+1], y[2i], y[2i-1]}.
  // Negative digits are emitted as the one's complement; the matching +1
  // goes into the correction row so no separate adder is needed.
  function automatic logic [PW-1:0] booth_row(input logic [2:0] trip,
                                              input logic [PW-1:0] m);
    logic          one;
    logic          two;
    logic [PW-1:0] mag;
    one = trip[1] ^ trip[0];
    two = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    mag = one ? m : (two ? (m << 1) : '0);
    return trip[2] ? ~mag : mag;
  endfunction

  // Pick the architectural result bits out of the full product.
  function automatic logic [XLEN-1:0] select_result(input logic [2:0] o,
                                                    input logic [PW-1:0] p);
    case (o)
      OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
      OP_MULW:                      return XLEN'($signed(p[31:0]));
      default:                      return p[XLEN-1:0];
    endcase
  endfunction

  logic                     adv_p1;
  logic                     adv_p2;
  logic                     adv_p3;
  logic                     accept;

  logic                     vld_p1;
  logic                     vld_p2;
  logic                     vld_p3;

  logic signed [OW-1:0]     mcand_p0;
  logic signed [OW-1:0]     mplier_p0;
  logic [OW:0]              ybits_p0;
  logic [PW-1:0]            mwide_p0;
  logic [PW-1:0]            pp_p0 [NPP];
  logic [PW-1:0]            corr_p0;

  logic [PW-1:0]            pp_p1 [NPP];
  logic [PW-1:0]            corr_p1;
  logic [2:0]               op_p1;
  logic [TAG_W-1:0]         tag_p1;

  logic [PW-1:0]            sum_p1;
  logic [PW-1:0]            carry_p1;

  logic [PW-1:0]            sum_p2;
  logic [PW-1:0]            carry_p2;
  logic [2:0]               op_p2;
  logic [TAG_W-1:0]         tag_p2;

  logic [XLEN-1:0]          result_p3;
  logic [TAG_W-1:0]         tag_p3;

  // Each stage moves when it is empty or its successor moves.
  assign adv_p3    = !vld_p3 || out_ready;
  assign adv_p2    = !vld_p2 || adv_p3;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = adv_p1;
  assign accept    = in_valid && in_ready && !flush;

  assign out_valid = vld_p3;
  assign result    = result_p3;
  assign tag_out   = tag_p3;

  // Operand extension to XLEN+2 bits according to the signedness of the op.
  always_comb begin
    case (op)
      OP_MULHSU: begin
        mcand_p0  = OW'($signed(src1));
        mplier_p0 = OW'(src2);
      end
      OP_MULHU: begin
        mcand_p0  = OW'(src1);
        mplier_p0 = OW'(src2);
      end
      OP_MULW: begin
        mcand_p0  = OW'($signed(src1[31:0]));
        mplier_p0 = OW'($signed(src2[31:0]));
      end
      default: begin
        mcand_p0  = OW'($signed(src1));
        mplier_p0 = OW'($signed(src2));
      end
    endcase
  end

  assign ybits_p0 = {mplier_p0, 1'b0};
  assign mwide_p0 = PW'(mcand_p0);

  // Booth encode every multiplier digit into a shifted partial product.
  always_comb begin
    corr_p0 = '0;
    for (int i = 0; i < NPP; i++) begin
      pp_p0[i]       = booth_row(ybits_p0[2*i +: 3], mwide_p0) << (2 * i);
      corr_p0[2*i]   = ybits_p0[2*i+2];
    end
  end

  // ---- stage 1 boundary: partial products ----
  // Capture partial products and sideband when stage 1 may advance.
  always_ff @(posedge clk) begin
    if (adv_p1) begin
      pp_p1   <= pp_p0;
      corr_p1 <= corr_p0;
      op_p1   <= op;
      tag_p1  <= tag_in;
    end
  end

  // Carry-save tree: each level groups rows in threes into sum/carry pairs,
  // passing leftover rows through, until two rows remain.
  always_comb begin
    logic [PW-1:0] cur [NR];
    logic [PW-1:0] nxt [NR];
    int n;
    int m;
    int g;
    for (int j = 0; j < NPP; j++) cur[j] = pp_p1[j];
    cur[NPP] = corr_p1;
    n = NR;
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < NR; j++) nxt[j] = '0;
      g = n / 3;
      m = 0;
      for (int k = 0; k < NR / 3; k++) begin
        if (k < g) begin
          nxt[m]   = cur[3*k] ^ cur[3*k+1] ^ cur[3*k+2];
          nxt[m+1] = ((cur[3*k] & cur[3*k+1]) | (cur[3*k] & cur[3*k+2]) |
                      (cur[3*k+1] & cur[3*k+2])) << 1;
          m = m + 2;
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (j >= 3 * g && j < n) begin
          nxt[m] = cur[j];
          m = m + 1;
        end
      end
      cur = nxt;
      n   = m;
    end
    sum_p1   = cur[0];
    carry_p1 = cur[1];
  end

  // ---- stage 2 boundary: sum/carry rows ----
  // Capture the two reduced rows when stage 2 may advance.
  always_ff @(posedge clk) begin
    if (adv_p2) begin
      sum_p2   <= sum_p1;
      carry_p2 <= carry_p1;
      op_p2    <= op_p1;
      tag_p2   <= tag_p1;
    end
  end

  // ---- stage 3 boundary: final add and result select ----
  // Output registers; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p3 <= '0;
      tag_p3    <= '0;
    end else if (adv_p3) begin
      result_p3 <= select_result(op_p2, sum_p2 + carry_p2);
      tag_p3    <= tag_p2;
    end
  end

  // Stage valid bits; flush empties the whole pipe at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= accept;
      if (adv_p2) vld_p2 <= vld_p1;
      if (adv_p3) vld_p3 <= vld_p2;
    end
  end

endmodule
